// File: rtl/skeeball_pkg.sv
// Shared types and constants for the skee-ball score keeper: state encoding,
// per-hole point values (in tens) and default game parameters.
package skeeball_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam int DEFAULT_BALLS     = 9;
  localparam int DEFAULT_GAME_SECS = 60;

  localparam logic [2:0] HOLE0_POINTS = 3'd1;
  localparam logic [2:0] HOLE1_POINTS = 3'd2;
  localparam logic [2:0] HOLE2_POINTS = 3'd3;
  localparam logic [2:0] HOLE3_POINTS = 3'd4;
  localparam logic [2:0] HOLE4_POINTS = 3'd5;

  // Only the highest rising hole scores; zero means no scoring hit this cycle.
  function automatic logic [2:0] priority_points(input logic [4:0] rise);
    logic [2:0] pts;
    pts = 3'd0;
    if      (rise[4]) pts = HOLE4_POINTS;
    else if (rise[3]) pts = HOLE3_POINTS;
    else if (rise[2]) pts = HOLE2_POINTS;
    else if (rise[1]) pts = HOLE1_POINTS;
    else if (rise[0]) pts = HOLE0_POINTS;
    return pts;
  endfunction

endpackage

// File: rtl/skeeball_bcd_add.sv
// Combinational BCD adder: adds 1-5 tens to a two-digit {hundreds, tens}
// score and saturates at 99 tens.
module skeeball_bcd_add
  import skeeball_pkg::*;
(
  input  logic [7:0] score_in,
  input  logic [2:0] points,
  output logic [7:0] score_out
);

  logic [4:0] tens_sum;

  always_comb begin
    tens_sum  = {1'b0, score_in[3:0]} + {2'b00, points};
    score_out = {score_in[7:4], tens_sum[3:0]};
    if (tens_sum > 5'd9) begin
      if (score_in[7:4] == 4'd9) begin
        score_out = 8'h99;
      end else begin
        score_out = {score_in[7:4] + 4'd1, 4'(tens_sum - 5'd10)};
      end
    end
  end

endmodule

// File: rtl/skeeball_score_keeper.sv
// Skee-ball game control: hole-hit edge detection and priority, BCD score
// accumulation, ball and time down-counters, and the IDLE/PLAY/OVER sequencer.
module skeeball_score_keeper
  import skeeball_pkg::*;
#(
  parameter int BALLS     = DEFAULT_BALLS,
  parameter int GAME_SECS = DEFAULT_GAME_SECS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  hole_hit,
  input  logic        tick_1hz,
  output logic [11:0] score_bcd,
  output logic [3:0]  balls_left,
  output logic [6:0]  time_left,
  output logic [1:0]  state,
  output logic        game_over
);

  state_t     state_q, state_n;
  logic [4:0] hit_q;
  logic [7:0] score_q, score_n, score_sum;
  logic [3:0] balls_q, balls_n;
  logic [6:0] time_q, time_n;
  logic [4:0] hit_rise;
  logic [2:0] hit_points;

  assign hit_rise   = hole_hit & ~hit_q;
  assign hit_points = priority_points(hit_rise);

  skeeball_bcd_add u_bcd_add (
    .score_in  (score_q),
    .points    (hit_points),
    .score_out (score_sum)
  );

  // Counters are tested after update so a hit or tick landing on zero ends the game next cycle.
  always_comb begin
    state_n = state_q;
    score_n = score_q;
    balls_n = balls_q;
    time_n  = time_q;
    case (state_q)
      PLAY: begin
        if (hit_points != 3'd0) begin
          score_n = score_sum;
          balls_n = balls_q - 4'd1;
        end
        if (tick_1hz) begin
          time_n = time_q - 7'd1;
        end
        if (balls_n == 4'd0 || time_n == 7'd0) begin
          state_n = OVER;
        end
      end
      default: begin
        if (start) begin
          state_n = PLAY;
          score_n = 8'h00;
          balls_n = 4'(BALLS);
          time_n  = 7'(GAME_SECS);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hit_q   <= 5'd0;
      score_q <= 8'h00;
      balls_q <= 4'd0;
      time_q  <= 7'd0;
    end else begin
      state_q <= state_n;
      hit_q   <= hole_hit;
      score_q <= score_n;
      balls_q <= balls_n;
      time_q  <= time_n;
    end
  end

  assign score_bcd  = {score_q, 4'h0};
  assign balls_left = balls_q;
  assign time_left  = time_q;
  assign state      = state_q;
  assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_skeeball_score_keeper.sv
// Self-checking bench: two score keepers (60 s and 3 s games) driven in lockstep
// and compared every cycle against an integer-arithmetic game model.
module tb_skeeball_score_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  hole_hit;
  logic        tick_1hz;

  logic [11:0] score_o [2];
  logic [3:0]  balls_o [2];
  logic [6:0]  time_o  [2];
  logic [1:0]  state_o [2];
  logic        over_o  [2];

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  int         m_state [2];
  int         m_score [2];
  int         m_balls [2];
  int         m_time  [2];
  logic [4:0] m_prev;

  always #5 clk = ~clk;

  skeeball_score_keeper #(.BALLS(9), .GAME_SECS(60)) dut_long (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .hole_hit   (hole_hit),
    .tick_1hz   (tick_1hz),
    .score_bcd  (score_o[0]),
    .balls_left (balls_o[0]),
    .time_left  (time_o[0]),
    .state      (state_o[0]),
    .game_over  (over_o[0])
  );

  skeeball_score_keeper #(.BALLS(9), .GAME_SECS(3)) dut_short (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .hole_hit   (hole_hit),
    .tick_1hz   (tick_1hz),
    .score_bcd  (score_o[1]),
    .balls_left (balls_o[1]),
    .time_left  (time_o[1]),
    .state      (state_o[1]),
    .game_over  (over_o[1])
  );

  function automatic int game_secs(input int k);
    return (k == 0) ? 60 : 3;
  endfunction

  function automatic logic [11:0] to_bcd(input int s);
    return {4'(s / 100), 4'((s / 10) % 10), 4'd0};
  endfunction

  // Model state: 0 idle, 1 play, 2 over; score held as plain points.
  task automatic model_step();
    logic [4:0] rise;
    int pts;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_state[k] = 0; m_score[k] = 0; m_balls[k] = 0; m_time[k] = 0;
      end
      m_prev = 5'd0;
    end else begin
      rise = hole_hit & ~m_prev;
      pts = 0;
      for (int i = 4; i >= 0; i--) begin
        if (pts == 0 && rise[i]) pts = 10 * (i + 1);
      end
      for (int k = 0; k < 2; k++) begin
        if (m_state[k] != 1) begin
          if (start) begin
            m_state[k] = 1; m_score[k] = 0; m_balls[k] = 9; m_time[k] = game_secs(k);
          end
        end else begin
          if (pts > 0) begin
            m_score[k] = (m_score[k] + pts > 990) ? 990 : m_score[k] + pts;
            m_balls[k] = m_balls[k] - 1;
          end
          if (tick_1hz) m_time[k] = m_time[k] - 1;
          if (m_balls[k] == 0 || m_time[k] == 0) m_state[k] = 2;
        end
      end
      m_prev = hole_hit;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_output();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("dut%0d.state", k), 32'(state_o[k]), 32'(m_state[k]));
      check_val($sformatf("dut%0d.score_bcd", k), 32'(score_o[k]), 32'(to_bcd(m_score[k])));
      check_val($sformatf("dut%0d.balls_left", k), 32'(balls_o[k]), 32'(m_balls[k]));
      check_val($sformatf("dut%0d.time_left", k), 32'(time_o[k]), 32'(m_time[k]));
      check_val($sformatf("dut%0d.game_over", k), 32'(over_o[k]), 32'(m_state[k] == 2));
    end
  endtask

  task automatic apply_stimulus(input logic st, input logic [4:0] hh, input logic tk);
    @(negedge clk);
    start    = st;
    hole_hit = hh;
    tick_1hz = tk;
    model_step();
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic hit_and_gap(input logic [4:0] hh);
    apply_stimulus(1'b0, hh, 1'b0);
    apply_stimulus(1'b0, 5'd0, 1'b0);
    apply_stimulus(1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hole_hit = 5'd0; tick_1hz = 1'b0;
    apply_stimulus(1'b0, 5'd0, 1'b0);
    apply_stimulus(1'b0, 5'd0, 1'b0);
    reset = 1'b0;
    apply_stimulus(1'b0, 5'd0, 1'b0);

    // Start, then a held hole, then simultaneous rises, then a carry sequence.
    apply_stimulus(1'b1, 5'd0, 1'b0);
    check_val("plan.start_balls", 32'(balls_o[0]), 32'd9);
    check_val("plan.start_time", 32'(time_o[0]), 32'd60);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 5'b10000, 1'b0);
    check_val("plan.held_score", 32'(score_o[0]), 32'h050);
    apply_stimulus(1'b0, 5'd0, 1'b0);
    hit_and_gap(5'b00101);
    hit_and_gap(5'b10000);
    hit_and_gap(5'b10000);
    hit_and_gap(5'b01000);
    check_val("plan.carry_score", 32'(score_o[0]), 32'h220);

    // Start during PLAY is ignored; use up the remaining balls, then hits after OVER.
    apply_stimulus(1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) hit_and_gap(5'b10000);
    hit_and_gap(5'b00001);

    // Fresh game with nine 50-point hits.
    apply_stimulus(1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 9; i++) hit_and_gap(5'b10000);
    check_val("plan.nine_hits", 32'(score_o[0]), 32'h450);
    hit_and_gap(5'b10000);
    apply_stimulus(1'b1, 5'd0, 1'b0);

    // Time-out on the short game, then a hit coincident with its final tick.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 5'd0, 1'b1);
      apply_stimulus(1'b0, 5'd0, 1'b0);
    end
    check_val("plan.timeout_time", 32'(time_o[1]), 32'd0);
    apply_stimulus(1'b1, 5'd0, 1'b0);
    apply_stimulus(1'b0, 5'd0, 1'b1);
    apply_stimulus(1'b0, 5'd0, 1'b1);
    apply_stimulus(1'b0, 5'b10000, 1'b1);
    check_val("plan.last_tick_hit", 32'(score_o[1]), 32'h050);

    // Reset mid-game overrides a coincident hit and tick.
    apply_stimulus(1'b0, 5'd0, 1'b0);
    reset = 1'b1;
    apply_stimulus(1'b0, 5'b00010, 1'b1);
    reset = 1'b0;
    apply_stimulus(1'b0, 5'd0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      apply_stimulus($urandom_range(0, 19) == 0,
                     ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'd0,
                     $urandom_range(0, 7) == 0);
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
